// File: rtl/iir_mac_sequencer_pkg.sv
// Shared types and constants for the biquad MAC sequencer slice.
package iir_pkg;

  localparam int unsigned FRAC_BITS_DEFAULT = 4;
  localparam int unsigned ACC_W_DEFAULT     = 20;
  localparam int unsigned N_TAPS_DEFAULT    = 5;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FIN,
    OUT
  } state_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
  } sm8_t;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  // Feedback taps are subtracted from the accumulator.
  function automatic logic isFeedbackTap(input logic [2:0] tap);
    return tap >= TAP_A1;
  endfunction

endpackage

// File: rtl/iir_mac_sequencer_if.sv
// Sample-in / filtered-out stream handshake bundle of the sequencer.
interface iir_mac_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_mag;
  logic       in_sign;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_mag;
  logic       out_sign;
  logic       out_sat;
  logic       out_mulovf;

  modport master (
    output in_valid, in_mag, in_sign, out_ready,
    input  in_ready, out_valid, out_mag, out_sign, out_sat, out_mulovf
  );

  modport slave (
    input  in_valid, in_mag, in_sign, out_ready,
    output in_ready, out_valid, out_mag, out_sign, out_sat, out_mulovf
  );
endinterface

// File: rtl/iir_mac_sequencer_sm_saturate.sv
// Signed accumulator to sign-magnitude byte: |acc| >> FRAC_BITS with clamp at 255.
module sm_saturate
  import iir_pkg::*;
#(
  parameter int unsigned ACC_W     = ACC_W_DEFAULT,
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic signed [ACC_W-1:0] acc,
  output sm8_t                    res,
  output logic                    sat
);

  logic [ACC_W-1:0] absVal;
  logic [ACC_W-1:0] shifted;

  always_comb begin
    absVal   = acc[ACC_W-1] ? -acc : acc;
    shifted  = absVal >> FRAC_BITS;
    sat      = |shifted[ACC_W-1:8];
    res.mag  = sat ? 8'hFF : shifted[7:0];
    // A magnitude that truncates to zero is reported as +0.
    res.sign = acc[ACC_W-1] && (res.mag != '0);
  end

endmodule

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I biquad sequencer sharing one external sign-magnitude multiplier over five taps.
module iir_mac_sequencer
  import iir_pkg::*;
#(
  parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT,
  parameter int unsigned ACC_W     = ACC_W_DEFAULT,
  parameter int unsigned N_TAPS    = N_TAPS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [7:0]           cfg_mag,
  input  logic                 cfg_sign,
  input  logic                 clear,
  iir_mac_sequencer_if.slave   stream,
  output logic [7:0]           mul_opA,
  output logic                 mul_signA,
  output logic [7:0]           mul_opB,
  output logic                 mul_signB,
  input  logic [15:0]          mul_out,
  input  logic                 mul_ovf,
  input  logic                 mul_sign
);

  localparam logic [2:0] LAST_TAP  = 3'(N_TAPS - 1);
  localparam logic [2:0] TAP_COUNT = 3'(N_TAPS);

  state_t state, nextState;

  sm8_t                    coef [N_TAPS];
  sm8_t                    x0, x1, x2, y1, y2;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic [2:0]              tap;
  logic                    effNeg;
  logic                    accept;
  logic                    inReady;
  logic                    outValid;
  logic [7:0]              outMag;
  logic                    outSign;
  logic                    outSat;
  logic                    mulOvfSticky;
  sm8_t                    opNextA, opNextB;
  sm8_t                    satRes;
  logic                    satFlag;

  sm_saturate #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS)
  ) uSat (
    .acc(acc),
    .res(satRes),
    .sat(satFlag)
  );

  assign accept = (state == IDLE) && stream.in_valid && inReady;
  assign prod   = {{(ACC_W-16){1'b0}}, mul_out};
  assign effNeg = mul_sign ^ isFeedbackTap(tap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept) nextState = MAC;
      MAC:  if (tap == LAST_TAP) nextState = FIN;
      FIN:  nextState = OUT;
      OUT:  if (stream.out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    inReady  = (state == IDLE) && !clear;
    outValid = (state == OUT);
  end

  // Operands are registered one tap ahead so the product of tap k is present during MAC tap k.
  always_comb begin
    opNextA = '0;
    opNextB = '0;
    if (accept) begin
      opNextA = coef[TAP_B0];
      opNextB = {stream.in_sign, stream.in_mag};
    end else if (state == MAC && tap != LAST_TAP) begin
      unique case (tap + 3'd1)
        TAP_B1: begin opNextA = coef[TAP_B1]; opNextB = x1; end
        TAP_B2: begin opNextA = coef[TAP_B2]; opNextB = x2; end
        TAP_A1: begin opNextA = coef[TAP_A1]; opNextB = y1; end
        TAP_A2: begin opNextA = coef[TAP_A2]; opNextB = y2; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_TAPS; i++) coef[i] <= '0;
      x0           <= '0;
      x1           <= '0;
      x2           <= '0;
      y1           <= '0;
      y2           <= '0;
      acc          <= '0;
      tap          <= TAP_B0;
      mulOvfSticky <= 1'b0;
      outMag       <= '0;
      outSign      <= 1'b0;
      outSat       <= 1'b0;
      mul_opA      <= '0;
      mul_signA    <= 1'b0;
      mul_opB      <= '0;
      mul_signB    <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr < TAP_COUNT) coef[cfg_addr] <= {cfg_sign, cfg_mag};
      mul_opA   <= opNextA.mag;
      mul_signA <= opNextA.sign;
      mul_opB   <= opNextB.mag;
      mul_signB <= opNextB.sign;
      unique case (state)
        IDLE: begin
          if (clear) begin
            x1  <= '0;
            x2  <= '0;
            y1  <= '0;
            y2  <= '0;
            acc <= '0;
          end else if (accept) begin
            x0           <= {stream.in_sign, stream.in_mag};
            acc          <= '0;
            tap          <= TAP_B0;
            mulOvfSticky <= 1'b0;
          end
        end
        MAC: begin
          acc          <= effNeg ? acc - prod : acc + prod;
          mulOvfSticky <= mulOvfSticky | mul_ovf;
          tap          <= (tap == LAST_TAP) ? TAP_B0 : tap + 3'd1;
        end
        FIN: begin
          outMag  <= satRes.mag;
          outSign <= satRes.sign;
          outSat  <= satFlag;
          x2      <= x1;
          x1      <= x0;
          y2      <= y1;
          y1      <= satRes;
        end
        OUT: ;
        default: ;
      endcase
    end
  end

  assign stream.in_ready   = inReady;
  assign stream.out_valid  = outValid;
  assign stream.out_mag    = outMag;
  assign stream.out_sign   = outSign;
  assign stream.out_sat    = outSat;
  assign stream.out_mulovf = mulOvfSticky;

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Directed scoreboard bench for iir_mac_sequencer with a behavioural multiply unit alongside.
module tb_iir_mac_sequencer;

  typedef struct packed {
    logic [7:0] mag;
    logic       sign;
    logic       sat;
    logic       ovf;
  } expT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfgWe = 1'b0;
  logic [2:0]  cfgAddr = '0;
  logic [7:0]  cfgMag = '0;
  logic        cfgSign = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  mulOpA, mulOpB;
  logic        mulSignA, mulSignB;
  logic [15:0] mulOut;
  logic        mulOvf, mulSign;

  int  errors = 0;
  int  checks = 0;
  expT sb[$];

  int mCoefMag [5];
  bit mCoefSgn [5];
  int mX1, mX2, mY1, mY2;

  iir_mac_sequencer_if bus();

  iir_mac_sequencer #(
    .FRAC_BITS(4),
    .ACC_W    (20),
    .N_TAPS   (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfgWe),
    .cfg_addr (cfgAddr),
    .cfg_mag  (cfgMag),
    .cfg_sign (cfgSign),
    .clear    (clear),
    .stream   (bus),
    .mul_opA  (mulOpA),
    .mul_signA(mulSignA),
    .mul_opB  (mulOpB),
    .mul_signB(mulSignB),
    .mul_out  (mulOut),
    .mul_ovf  (mulOvf),
    .mul_sign (mulSign)
  );

  // External sign-magnitude multiply unit.
  assign mulOut  = 16'(mulOpA) * 16'(mulOpB);
  assign mulOvf  = |mulOut[15:8];
  assign mulSign = mulSignA ^ mulSignB;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 5; i++) begin
      mCoefMag[i] = 0;
      mCoefSgn[i] = 1'b0;
    end
    mX1 = 0; mX2 = 0; mY1 = 0; mY2 = 0;
  endfunction

  function automatic expT modelStep(input int xm, input bit xs);
    int  h [5];
    int  acc, c, p, a, r;
    expT e;
    e = '0;
    h[0] = xs ? -xm : xm;
    h[1] = mX1; h[2] = mX2; h[3] = mY1; h[4] = mY2;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      c = mCoefSgn[i] ? -mCoefMag[i] : mCoefMag[i];
      p = c * h[i];
      if ((p < 0 ? -p : p) > 255) e.ovf = 1'b1;
      acc = (i >= 3) ? acc - p : acc + p;
    end
    a = (acc < 0) ? -acc : acc;
    r = a / 16;
    e.sat  = (r > 255);
    e.mag  = e.sat ? 8'd255 : 8'(r);
    e.sign = (acc < 0) && (e.mag != 0);
    mX2 = mX1;
    mX1 = h[0];
    mY2 = mY1;
    mY1 = e.sign ? -int'(e.mag) : int'(e.mag);
    return e;
  endfunction

  task automatic setCoef(input int addr, input int mag, input bit sgn);
    cfgWe = 1'b1; cfgAddr = 3'(addr); cfgMag = 8'(mag); cfgSign = sgn;
    @(posedge clk); #1;
    cfgWe = 1'b0;
    if (addr < 5) begin
      mCoefMag[addr] = mag;
      mCoefSgn[addr] = sgn;
    end
  endtask

  task automatic pulseClear();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    clear = 1'b1; #1;
    chk("clear_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    mX1 = 0; mX2 = 0; mY1 = 0; mY2 = 0;
  endtask

  task automatic driveSample(input int mag, input bit sgn);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    chk("in_ready_wait", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_mag = 8'(mag); bus.in_sign = sgn;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(modelStep(mag, sgn));
  endtask

  // Called right after the accepting edge; edges counted until out_valid.
  task automatic collect();
    int  n = 0;
    expT e;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 6);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("out_mag", 32'(bus.out_mag), 32'(e.mag));
      chk("out_sign", 32'(bus.out_sign), 32'(e.sign));
      chk("out_sat", 32'(bus.out_sat), 32'(e.sat));
      chk("out_mulovf", 32'(bus.out_mulovf), 32'(e.ovf));
    end
  endtask

  task automatic runSample(input int mag, input bit sgn);
    driveSample(mag, sgn);
    collect();
  endtask

  initial begin
    logic [7:0] holdMag;
    logic       holdSign, holdSat, holdOvf;
    bus.in_valid = 1'b0; bus.in_mag = '0; bus.in_sign = 1'b0; bus.out_ready = 1'b1;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_mag", 32'(bus.out_mag), 0);
    chk("rst_out_sign", 32'(bus.out_sign), 0);
    chk("rst_out_sat", 32'(bus.out_sat), 0);
    chk("rst_out_mulovf", 32'(bus.out_mulovf), 0);
    chk("rst_mul_opA", 32'({mulSignA, mulOpA}), 0);
    chk("rst_mul_opB", 32'({mulSignB, mulOpB}), 0);

    // Passthrough, positive and negative samples.
    setCoef(0, 16, 1'b0);
    runSample(5, 1'b0);
    runSample(7, 1'b1);

    // Recursion: +16, -8, +4.
    pulseClear();
    setCoef(3, 8, 1'b0);
    runSample(16, 1'b0);
    runSample(0, 1'b0);
    runSample(0, 1'b0);

    // Clear restarts the impulse response.
    pulseClear();
    runSample(16, 1'b0);
    runSample(0, 1'b0);

    // Saturation under backpressure; saturated value feeds back through a1.
    pulseClear();
    setCoef(3, 0, 1'b0);
    setCoef(0, 255, 1'b0);
    bus.out_ready = 1'b0;
    driveSample(255, 1'b0);
    collect();
    holdMag = bus.out_mag; holdSign = bus.out_sign; holdSat = bus.out_sat; holdOvf = bus.out_mulovf;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_stable", 32'({bus.out_mag, bus.out_sign, bus.out_sat, bus.out_mulovf}),
          32'({holdMag, holdSign, holdSat, holdOvf}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(bus.out_valid), 0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 1);
    setCoef(3, 1, 1'b0);
    runSample(0, 1'b0);

    // Mixed-sign coefficients on all five taps.
    pulseClear();
    setCoef(0, 16, 1'b0);
    setCoef(1, 32, 1'b1);
    setCoef(2, 8, 1'b0);
    setCoef(3, 4, 1'b1);
    setCoef(4, 2, 1'b0);
    setCoef(6, 99, 1'b1);
    runSample(20, 1'b1);
    runSample(30, 1'b0);
    runSample(7, 1'b0);
    runSample(0, 1'b0);

    // Reset during MAC tap 2 abandons the sample and clears coefficients.
    driveSample(40, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    sb.delete();
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid2", 32'(bus.out_valid), 0);
    driveSample(9, 1'b0);
    chk("midrst_coef_b0", 32'({mulSignA, mulOpA}), 0);
    collect();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
